scan_harness: RTL and testbench

Parametrised serial-in/serial-out test harness that loads CH operand channels of W bits each from CH serial pins, presents them in parallel to a combinational compressor under test, captures its OUT_W-bit result, and streams the result out on a single pin. It is the framed, pin-efficient successor to the free-running per-channel shift registers used around generated compressors. It adds a start/capture/unload protocol, a shift-enable, and result readback, so wide compressors fit on small pin budgets.

---
 rtl/scan_harness.sv | 121 ++++++++++++
 tb/tb_scan_harness.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : scan_harness                                                     |
// | Brief   : Serial-in/serial-out framed harness around a combinational       |
// |           compressor: load CH x W operands, capture, unload OUT_W bits.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module scan_harness #(
    parameter int CH    = 22,
    parameter int W     = 22,
    parameter int OUT_W = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              shift_en,
    input  logic [CH-1:0]     src_in,
    output logic [CH*W-1:0]   src_flat,
    input  logic [OUT_W-1:0]  dst_flat,
    input  logic              capture,
    output logic              dst_out,
    output logic              dst_valid,
    input  logic              dst_ready,
    output logic              busy,
    output logic              loaded
);

    localparam int C_MAXN  = (W > OUT_W) ? W : OUT_W;
    localparam int C_CNT_W = $clog2(C_MAXN + 1);
    localparam logic [C_CNT_W-1:0] C_LOAD_LAST   = C_CNT_W'(W - 1);
    localparam logic [C_CNT_W-1:0] C_UNLOAD_LAST = C_CNT_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_READY  = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]     r_cap;
    logic                 w_shift;
    logic                 w_capture;
    logic                 w_xfer;

    assign w_shift   = (r_state == S_LOAD)   && shift_en;
    assign w_capture = (r_state == S_READY)  && capture;
    assign w_xfer    = (r_state == S_UNLOAD) && dst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_LOAD;
            S_LOAD:   if (shift_en && (r_cnt == C_LOAD_LAST)) w_state_nxt = S_READY;
            S_READY:  if (capture) w_state_nxt = S_UNLOAD;
            S_UNLOAD: if (dst_ready && (r_cnt == C_UNLOAD_LAST)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // One counter serves both the load and unload phases; it is cleared on entry to each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (((r_state == S_IDLE) && start) || w_capture) begin
            r_cnt <= '0;
        end else if (w_shift || w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap <= '0;
        end else if (w_capture) begin
            r_cap <= dst_flat;
        end else if (w_xfer) begin
            r_cap <= r_cap >> 1;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0] r_ch;
        if (W == 1) begin : g_w1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ch <= '0;
                end else if (w_shift) begin
                    r_ch <= src_in[c];
                end
            end
        end else begin : g_wn
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ch <= '0;
                end else if (w_shift) begin
                    r_ch <= {r_ch[W-2:0], src_in[c]};
                end
            end
        end
        assign src_flat[c*W +: W] = r_ch;
    end

    // Outputs are decodes of registers only; cap drains to zero so dst_out idles low.
    assign dst_out   = r_cap[0];
    assign dst_valid = (r_state == S_UNLOAD);
    assign busy      = (r_state != S_IDLE);
    assign loaded    = (r_state == S_READY);

endmodule
`default_nettype wire

// File: tb/tb_scan_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_scan_harness                                                  |
// | Brief   : Directed self-checking bench for scan_harness (CH=2, W=4, OUT_W=28)|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_scan_harness;

    localparam int CH    = 2;
    localparam int W     = 4;
    localparam int OUT_W = 28;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              shift_en;
    logic [CH-1:0]     src_in;
    logic [CH*W-1:0]   src_flat;
    logic [OUT_W-1:0]  dst_flat;
    logic              capture;
    logic              dst_out;
    logic              dst_valid;
    logic              dst_ready;
    logic              busy;
    logic              loaded;

    int n_cmp = 0;
    int n_err = 0;

    scan_harness #(.CH(CH), .W(W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift_en  (shift_en),
        .src_in    (src_in),
        .src_flat  (src_flat),
        .dst_flat  (dst_flat),
        .capture   (capture),
        .dst_out   (dst_out),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .busy      (busy),
        .loaded    (loaded)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic b0, input logic b1);
        src_in   = {b1, b0};
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        src_in   = 2'b00;
    endtask

    // Drains up to 'limit' accepted bits; optional alternating back-pressure,
    // with start/capture misuse pulses during the first cycles.
    task automatic unload(input bit alt, input int limit,
                          output logic [OUT_W-1:0] word, output int nacc);
        int   cyc;
        logic prev;
        bit   rdy;
        word = '0;
        nacc = 0;
        cyc  = 0;
        while (nacc < limit && cyc < 200) begin
            rdy       = alt ? (cyc % 2 == 0) : 1'b1;
            dst_ready = rdy;
            start     = (cyc < 4);
            capture   = (cyc < 4);
            prev      = dst_out;
            if (dst_valid && rdy) begin
                word[nacc] = dst_out;
                nacc++;
            end
            tick();
            cyc++;
            if (!rdy) check("stall_hold", {63'd0, dst_out}, {63'd0, prev});
        end
        start     = 1'b0;
        capture   = 1'b0;
        dst_ready = 1'b0;
        check("unload_count", 64'(nacc), 64'(limit));
    endtask

    logic [OUT_W-1:0] word;
    int               nacc;

    initial begin
        rst = 1'b1; start = 1'b0; shift_en = 1'b0; src_in = '0;
        dst_flat = '0; capture = 1'b0; dst_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_src_flat", 64'(src_flat), 64'd0);
        check("rst_dst_out", {63'd0, dst_out}, 64'd0);
        check("rst_dst_valid", {63'd0, dst_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_loaded", {63'd0, loaded}, 64'd0);

        // Frame 1: continuous load, start misuse during load, capture coincident with completion
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_loaded", {63'd0, loaded}, 64'd0);
        shift_bit(1, 0);
        start = 1'b1;
        shift_bit(0, 1);
        start = 1'b0;
        shift_bit(1, 1);
        check("load3_loaded", {63'd0, loaded}, 64'd0);
        capture = 1'b1;
        shift_bit(1, 0);
        capture = 1'b0;
        check("load4_loaded", {63'd0, loaded}, 64'd1);
        check("load4_src_flat", 64'(src_flat), 64'h6B);
        check("load4_no_capture", {63'd0, dst_valid}, 64'd0);
        tick();
        check("ready_hold_loaded", {63'd0, loaded}, 64'd1);
        check("ready_hold_src", 64'(src_flat), 64'h6B);

        dst_flat = 28'hABCDEF1;
        capture  = 1'b1;
        tick();
        capture  = 1'b0;
        dst_flat = 28'h0000000;
        check("cap_valid", {63'd0, dst_valid}, 64'd1);
        check("cap_dst_out", {63'd0, dst_out}, 64'd1);
        check("cap_loaded", {63'd0, loaded}, 64'd0);
        unload(1'b1, OUT_W, word, nacc);
        check("unload_first8", 64'(word[7:0]), 64'hF1);
        check("unload_word", 64'(word), 64'hABCDEF1);
        check("unload_end_busy", {63'd0, busy}, 64'd0);
        check("unload_end_valid", {63'd0, dst_valid}, 64'd0);
        check("unload_end_dst_out", {63'd0, dst_out}, 64'd0);

        // IDLE misuse: capture alone, then start+capture together
        dst_flat = 28'hFFFFFFF;
        capture  = 1'b1;
        tick();
        check("idle_cap_busy", {63'd0, busy}, 64'd0);
        check("idle_cap_valid", {63'd0, dst_valid}, 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        capture = 1'b0;
        check("sc_busy", {63'd0, busy}, 64'd1);
        check("sc_valid", {63'd0, dst_valid}, 64'd0);

        // Paused load: same data, 3 idle cycles between bits 2 and 3 with src_in toggling
        shift_bit(1, 0);
        shift_bit(0, 1);
        check("pause_partial", 64'(src_flat), 64'h9E);
        for (int i = 0; i < 3; i++) begin
            src_in = (i % 2 == 0) ? 2'b11 : 2'b01;
            tick();
            check("pause_src_hold", 64'(src_flat), 64'h9E);
            check("pause_loaded", {63'd0, loaded}, 64'd0);
        end
        shift_bit(1, 1);
        check("pause3_loaded", {63'd0, loaded}, 64'd0);
        shift_bit(1, 0);
        check("pause4_loaded", {63'd0, loaded}, 64'd1);
        check("pause4_src_flat", 64'(src_flat), 64'h6B);

        // Reset mid-unload after 10 bits
        dst_flat = 28'h5A5A5A5;
        capture  = 1'b1;
        tick();
        capture  = 1'b0;
        unload(1'b0, 10, word, nacc);
        check("partial_bits", 64'(word[9:0]), 64'h1A5);
        #2;
        rst = 1'b1;
        #1;
        check("amid_src_flat", 64'(src_flat), 64'd0);
        check("amid_dst_out", {63'd0, dst_out}, 64'd0);
        check("amid_dst_valid", {63'd0, dst_valid}, 64'd0);
        check("amid_busy", {63'd0, busy}, 64'd0);
        check("amid_loaded", {63'd0, loaded}, 64'd0);
        dst_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", {63'd0, dst_valid}, 64'd0);
        dst_ready = 1'b0;

        // Start accepted on the first edge after release, then a full fresh frame
        start = 1'b1;
        tick();
        start = 1'b0;
        check("frame2_busy", {63'd0, busy}, 64'd1);
        shift_bit(0, 1);
        shift_bit(1, 0);
        shift_bit(1, 0);
        shift_bit(1, 1);
        check("frame2_loaded", {63'd0, loaded}, 64'd1);
        check("frame2_src_flat", 64'(src_flat), 64'h97);
        dst_flat = 28'h1234567;
        capture  = 1'b1;
        tick();
        capture  = 1'b0;
        unload(1'b0, OUT_W, word, nacc);
        check("frame2_word", 64'(word), 64'h1234567);
        check("frame2_end_busy", {63'd0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
